// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field layout, TX state encoding and the
// priority helper used to walk the destination mask.
package noc_pkg;

  localparam int PKT_WIDTH    = 32;
  localparam int PKT_DEST_MSB = 31;
  localparam int PKT_ID_LSB   = 0;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int lowest_set_idx(input logic [31:0] mask);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO buffering received spikes for the neuron core.
// The head word reads as zero while the FIFO is empty.
module ni_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spike_network_interface.sv
// Network interface beside each router: fans spikes out as NoC packets to the
// configured destinations and buffers correctly addressed incoming spikes.
module spike_network_interface
  import noc_pkg::*;
#(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int NEURON_ID_WIDTH   = 8,
  parameter int MAX_DEST          = 4,
  parameter int RX_FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_addr,
  input  logic                         cfg_we,
  input  logic [$clog2(MAX_DEST)-1:0]  cfg_idx,
  input  logic [ROUTER_ADDR_WIDTH-1:0] cfg_dest,
  input  logic                         cfg_en,
  input  logic                         spike_valid,
  input  logic [NEURON_ID_WIDTH-1:0]   spike_neuron_id,
  output logic                         spike_ready,
  output logic [31:0]                  net_out_packet,
  output logic                         net_out_valid,
  input  logic                         net_out_ready,
  input  logic [31:0]                  net_in_packet,
  input  logic                         net_in_valid,
  output logic                         net_in_ready,
  output logic                         rx_valid,
  output logic [ROUTER_ADDR_WIDTH-1:0] rx_src_addr,
  output logic [NEURON_ID_WIDTH-1:0]   rx_neuron_id,
  input  logic                         rx_ready,
  output logic                         tx_busy,
  output logic                         err_misroute
);

  localparam int W       = ROUTER_ADDR_WIDTH;
  localparam int NID_W   = NEURON_ID_WIDTH;
  localparam int IDX_W   = $clog2(MAX_DEST);
  localparam int SRC_MSB = PKT_DEST_MSB - W;
  localparam int RX_W    = W + NID_W;
  localparam int CNT_W   = $clog2(RX_FIFO_DEPTH) + 1;

  logic [MAX_DEST-1:0] tab_en_r;
  logic [W-1:0]        tab_dest_r [MAX_DEST];

  tx_state_e           state_r;
  logic [MAX_DEST-1:0] mask_r;
  logic [W-1:0]        dest_snap_r [MAX_DEST];
  logic [NID_W-1:0]    nid_r;
  logic [IDX_W-1:0]    sel_r;
  logic [31:0]         pkt_r;
  logic                valid_r;

  logic [IDX_W-1:0]    cap_idx_s;
  logic [IDX_W-1:0]    nxt_idx_s;
  logic [MAX_DEST-1:0] nxt_mask_s;

  function automatic logic [31:0] build_pkt(input logic [W-1:0] dest,
                                            input logic [W-1:0] src,
                                            input logic [NID_W-1:0] nid);
    logic [31:0] p;
    p = 32'd0;
    p[PKT_DEST_MSB -: W]             = dest;
    p[SRC_MSB -: W]                  = src;
    p[PKT_ID_LSB +: NID_W]           = nid;
    return p;
  endfunction

  // Destination selection for a fresh capture and for the next fan-out step.
  always_comb begin
    cap_idx_s  = IDX_W'(lowest_set_idx(32'(tab_en_r)));
    nxt_mask_s = mask_r & ~({{(MAX_DEST-1){1'b0}}, 1'b1} << sel_r);
    nxt_idx_s  = IDX_W'(lowest_set_idx(32'(nxt_mask_s)));
  end

  // Destination table write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      tab_en_r <= {MAX_DEST{1'b0}};
      for (int i = 0; i < MAX_DEST; i++) tab_dest_r[i] <= {W{1'b0}};
    end else if (cfg_we) begin
      tab_en_r[cfg_idx]   <= cfg_en;
      tab_dest_r[cfg_idx] <= cfg_dest;
    end
  end

  // TX fan-out FSM; the table is snapshotted so later writes only hit the next spike.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TX_IDLE;
      mask_r  <= {MAX_DEST{1'b0}};
      nid_r   <= {NID_W{1'b0}};
      sel_r   <= {IDX_W{1'b0}};
      pkt_r   <= 32'd0;
      valid_r <= 1'b0;
      for (int i = 0; i < MAX_DEST; i++) dest_snap_r[i] <= {W{1'b0}};
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (spike_valid) begin
            nid_r       <= spike_neuron_id;
            mask_r      <= tab_en_r;
            dest_snap_r <= tab_dest_r;
            if (tab_en_r != {MAX_DEST{1'b0}}) begin
              sel_r   <= cap_idx_s;
              pkt_r   <= build_pkt(tab_dest_r[cap_idx_s], router_addr, spike_neuron_id);
              valid_r <= 1'b1;
              state_r <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          if (net_out_ready) begin
            mask_r <= nxt_mask_s;
            if (nxt_mask_s == {MAX_DEST{1'b0}}) begin
              valid_r <= 1'b0;
              state_r <= TX_IDLE;
            end else begin
              sel_r <= nxt_idx_s;
              pkt_r <= build_pkt(dest_snap_r[nxt_idx_s], router_addr, nid_r);
            end
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= TX_IDLE;
        end
      endcase
    end
  end

  assign spike_ready    = (state_r == TX_IDLE);
  assign tx_busy        = (state_r != TX_IDLE);
  assign net_out_packet = pkt_r;
  assign net_out_valid  = valid_r;

  logic             rx_hs_s;
  logic             rx_match_s;
  logic             rx_push_s;
  logic             rx_pop_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic [RX_W-1:0]  rx_head_s;
  logic [CNT_W-1:0] rx_count_s;
  logic             err_r;
  logic             pkt_unused_s;

  assign net_in_ready = !rx_full_s;
  assign rx_hs_s      = net_in_valid && !rx_full_s;
  assign rx_match_s   = (net_in_packet[PKT_DEST_MSB -: W] == router_addr);
  assign rx_push_s    = rx_hs_s && rx_match_s && (rx_count_s < CNT_W'(RX_FIFO_DEPTH));
  assign rx_pop_s     = !rx_empty_s && rx_ready;
  // Padding bits between the source and neuron-ID fields carry no information.
  assign pkt_unused_s = ^net_in_packet[SRC_MSB-W:NID_W];

  ni_fifo #(
    .WIDTH (RX_W),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_s),
    .wdata ({net_in_packet[SRC_MSB -: W], net_in_packet[NID_W-1:0]}),
    .pop   (rx_pop_s),
    .rdata (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  // One-cycle pulse for every accepted packet that was not addressed here.
  always_ff @(posedge clk) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= rx_hs_s && !rx_match_s;
  end

  assign rx_valid     = !rx_empty_s;
  assign rx_src_addr  = rx_head_s[RX_W-1 -: W];
  assign rx_neuron_id = rx_head_s[NID_W-1:0];
  assign err_misroute = err_r;

endmodule
